// File: rtl/melody_sequencer_pkg.sv
// Shared types and constants for the melody sequencer: FSM state encoding,
// note divider values for the Do/Re/Mi keys and ROM entry field widths.
package melody_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int NOTE_W = 20;
  localparam int BEAT_W = 4;
  localparam int CNT_W  = 32;

  localparam logic [NOTE_W-1:0] NOTE_DO   = 20'd76628;
  localparam logic [NOTE_W-1:0] NOTE_RE   = 20'd68259;
  localparam logic [NOTE_W-1:0] NOTE_MI   = 20'd60606;
  localparam logic [NOTE_W-1:0] NOTE_REST = 20'd0;

endpackage

// File: rtl/melody_sequencer_rom.sv
// Synchronous melody ROM: entry = {div, beats}, one cycle read latency.
// MELODY_ID picks the stored tune (0 = Do-Re jingle, 1 = empty, other = Do-Re-Mi tune).
module melody_rom
  import melody_sequencer_pkg::*;
#(
  parameter int DIV_W     = 20,
  parameter int AW        = 5,
  parameter int MELODY_ID = 2
) (
  input  logic                    clk,
  input  logic [AW-1:0]           addr_i,
  output logic [DIV_W+BEAT_W-1:0] data_o
);

  logic [DIV_W+BEAT_W-1:0] word;
  logic [DIV_W+BEAT_W-1:0] data_q;

  always_comb begin
    word = '0;
    if (MELODY_ID == 0) begin
      case (addr_i)
        AW'(0):  word = {DIV_W'(NOTE_DO), BEAT_W'(1)};
        AW'(1):  word = {DIV_W'(NOTE_RE), BEAT_W'(2)};
        default: word = '0;
      endcase
    end else if (MELODY_ID == 1) begin
      word = '0;
    end else begin
      case (addr_i)
        AW'(0):  word = {DIV_W'(NOTE_DO),   BEAT_W'(1)};
        AW'(1):  word = {DIV_W'(NOTE_RE),   BEAT_W'(1)};
        AW'(2):  word = {DIV_W'(NOTE_MI),   BEAT_W'(1)};
        AW'(3):  word = {DIV_W'(NOTE_REST), BEAT_W'(1)};
        AW'(4):  word = {DIV_W'(NOTE_MI),   BEAT_W'(2)};
        AW'(5):  word = {DIV_W'(NOTE_RE),   BEAT_W'(1)};
        AW'(6):  word = {DIV_W'(NOTE_DO),   BEAT_W'(2)};
        default: word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    data_q <= word;
  end

  assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Steps the melody ROM and drives note_div; a held Do/Re/Mi key overrides the tune
// and freezes its timing. Define MELODY_LOOP_EN to replay the melody continuously.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int DIV_W          = 20,
  parameter int DEPTH          = 32,
  parameter int TICKS_PER_BEAT = 10_000_000,
  parameter int GAP_TICKS      = 400_000,
  parameter int MELODY_ID      = 2,
  localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             manual_req,
  input  logic [DIV_W-1:0] manual_div,
  output logic [DIV_W-1:0] note_div,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    note_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     seqDiv_q, seqDiv_d;
  logic [DIV_W-1:0]     noteDiv_q, noteDiv_d;
  logic                 done_q, done_d;

  logic [DIV_W+BEAT_W-1:0] romData;
  logic [DIV_W-1:0]        romDiv;
  logic [BEAT_W-1:0]       romBeats;
  logic [CNT_W-1:0]        loadCnt;
  logic                    holdSeq;
  logic                    isBusy;

  // The ROM is addressed with the next index so the entry is ready in LOAD.
  melody_rom #(
    .DIV_W     (DIV_W),
    .AW        (AW),
    .MELODY_ID (MELODY_ID)
  ) u_rom (
    .clk    (clk),
    .addr_i (idx_d),
    .data_o (romData)
  );

  assign {romDiv, romBeats} = romData;
  assign loadCnt = CNT_W'(romBeats) * CNT_W'(TICKS_PER_BEAT) - CNT_W'(GAP_TICKS) - CNT_W'(1);
  assign holdSeq = pause | manual_req;
  assign isBusy  = (state_q == S_LOAD) || (state_q == S_PLAY) || (state_q == S_GAP);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    seqDiv_d = seqDiv_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (!pause) begin
          if (romBeats == '0) begin
`ifdef MELODY_LOOP_EN
            // An end marker at entry 0 stops rather than spinning on an empty tune.
            if (idx_q == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
              idx_d   = '0;
              done_d  = 1'b1;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d  = S_PLAY;
            seqDiv_d = romDiv;
            cnt_d    = loadCnt;
          end
        end
      end
      S_PLAY: begin
        if (!holdSeq) begin
          if (cnt_q == '0) begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(GAP_TICKS - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (!holdSeq) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (idx_q == LAST_IDX) begin
`ifdef MELODY_LOOP_EN
            state_d = S_LOAD;
            idx_d   = '0;
            done_d  = 1'b1;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_LOAD;
            idx_d   = idx_q + AW'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
    if (stop) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  // Output arbitration: key first, then a paused tone is held, else the tune.
  always_comb begin
    noteDiv_d = '0;
    if (manual_req) begin
      noteDiv_d = manual_div;
    end else if (pause && isBusy && !stop) begin
      noteDiv_d = noteDiv_q;
    end else if (state_d == S_PLAY) begin
      noteDiv_d = seqDiv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      seqDiv_q  <= '0;
      noteDiv_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      seqDiv_q  <= seqDiv_d;
      noteDiv_q <= noteDiv_d;
      done_q    <= done_d;
    end
  end

  assign note_div = noteDiv_q;
  assign busy     = isBusy;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with short beats (100 ticks, 10-tick gap, 8 entries).
// Honours MELODY_LOOP_EN when the design is built with it.
module tb_melody_sequencer;

  localparam int DIV_W = 20;
  localparam int AW    = 3;
  localparam logic [DIV_W-1:0] DO = 20'd76628;
  localparam logic [DIV_W-1:0] RE = 20'd68259;
  localparam logic [DIV_W-1:0] MI = 20'd60606;

  typedef struct {
    logic             start;
    logic             stop;
    logic             pause;
    logic             mreq;
    logic [DIV_W-1:0] mdiv;
    int               cycles;
    logic [DIV_W-1:0] expDiv;
    logic             expBusy;
    logic             expDone;
    logic             chkIdx;
    logic [AW-1:0]    expIdx;
    string            name;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, pause, manual_req;
  logic [DIV_W-1:0] manual_div;
  logic [DIV_W-1:0] note_div;
  logic             busy, done;
  logic [AW-1:0]    note_idx;

  logic             startE;
  logic             zeroE = 1'b0;
  logic [DIV_W-1:0] zeroDivE = '0;
  logic [DIV_W-1:0] noteE;
  logic             busyE, doneE;
  logic [AW-1:0]    idxE;

  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs[$];

  int reCnt, miCnt, doneCnt, busyCnt, zeroRun, mLeft, pLeft, nzCnt;
  bit fin, injected, justInjected, justReleased, seenDo, paused;

  always #5 clk = ~clk;

  melody_sequencer #(
    .DIV_W(DIV_W), .DEPTH(8), .TICKS_PER_BEAT(100), .GAP_TICKS(10), .MELODY_ID(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .manual_req(manual_req), .manual_div(manual_div),
    .note_div(note_div), .busy(busy), .done(done), .note_idx(note_idx)
  );

  melody_sequencer #(
    .DIV_W(DIV_W), .DEPTH(8), .TICKS_PER_BEAT(100), .GAP_TICKS(10), .MELODY_ID(1)
  ) dutEmpty (
    .clk(clk), .rst(rst), .start(startE), .stop(zeroE), .pause(zeroE),
    .manual_req(zeroE), .manual_div(zeroDivE),
    .note_div(noteE), .busy(busyE), .done(doneE), .note_idx(idxE)
  );

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void addVec(input logic s, input logic p, input logic pa, input logic m,
                                 input logic [DIV_W-1:0] md, input int cyc,
                                 input logic [DIV_W-1:0] ed, input logic eb, input logic edn,
                                 input logic ci, input logic [AW-1:0] ei, input string nm);
    vec_t v;
    v.start = s; v.stop = p; v.pause = pa; v.mreq = m; v.mdiv = md; v.cycles = cyc;
    v.expDiv = ed; v.expBusy = eb; v.expDone = edn; v.chkIdx = ci; v.expIdx = ei; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    start = v.start; stop = v.stop; pause = v.pause;
    manual_req = v.mreq; manual_div = v.mdiv;
    repeat (v.cycles) tick();
    checkOutput({v.name, " note_div"}, int'(note_div), int'(v.expDiv));
    checkOutput({v.name, " busy"}, int'(busy), int'(v.expBusy));
    checkOutput({v.name, " done"}, int'(done), int'(v.expDone));
    if (v.chkIdx) checkOutput({v.name, " idx"}, int'(note_idx), int'(v.expIdx));
  endtask

  task automatic doReset();
    start = 0; stop = 0; pause = 0; manual_req = 0; manual_div = '0; startE = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    doReset();
    tick();
    checkOutput("reset note_div", int'(note_div), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset idx", int'(note_idx), 0);
    checkOutput("reset empty busy", int'(busyE), 0);

    // Test 1: full pass through {DO,1},{RE,2},{end}
    addVec(1,0,0,0,0,   1, 0,  1,0,1,0, "t1 load0");
    addVec(0,0,0,0,0,   1, DO, 1,0,1,0, "t1 do first");
    addVec(0,0,0,0,0,  89, DO, 1,0,1,0, "t1 do last");
    addVec(0,0,0,0,0,   1, 0,  1,0,1,0, "t1 gap0 first");
    addVec(0,0,0,0,0,   9, 0,  1,0,1,0, "t1 gap0 last");
    addVec(0,0,0,0,0,   1, 0,  1,0,1,1, "t1 load1");
    addVec(0,0,0,0,0,   1, RE, 1,0,1,1, "t1 re first");
    addVec(0,0,0,0,0, 189, RE, 1,0,1,1, "t1 re last");
    addVec(0,0,0,0,0,   1, 0,  1,0,1,1, "t1 gap1 first");
    addVec(0,0,0,0,0,   9, 0,  1,0,1,1, "t1 gap1 last");
    addVec(0,0,0,0,0,   1, 0,  1,0,1,2, "t1 load end");
`ifdef MELODY_LOOP_EN
    addVec(0,0,0,0,0,   1, 0,  1,1,1,0, "t1 wrap");
    addVec(0,0,0,0,0,   1, DO, 1,0,1,0, "t1 second pass");
    addVec(0,1,0,0,0,   1, 0,  0,0,0,0, "t1 stop loop");
`else
    addVec(0,0,0,0,0,   1, 0,  0,1,1,2, "t1 done pulse");
`endif
    addVec(0,0,0,0,0,   5, 0,  0,0,0,0, "t1 idle");
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Test 2: key press mid-RE must not shorten RE
    doReset();
    reCnt = 0; miCnt = 0; doneCnt = 0; mLeft = 0;
    fin = 0; injected = 0; justInjected = 0; justReleased = 0;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 2000 && !fin; k++) begin
      tick();
      if (note_div == RE) reCnt++;
      if (note_div == MI) miCnt++;
      if (done) begin doneCnt++; fin = 1; end
      if (justInjected) checkOutput("t2 manual latency", int'(note_div), int'(MI));
      if (justReleased) checkOutput("t2 resume re", int'(note_div), int'(RE));
      justInjected = 0; justReleased = 0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin manual_req = 0; justReleased = 1; end
      end else if (!injected && reCnt == 60) begin
        manual_req = 1; manual_div = MI; mLeft = 50; injected = 1; justInjected = 1;
      end
    end
    checkOutput("t2 finished", int'(fin), 1);
    checkOutput("t2 re cycles", reCnt, 190);
    checkOutput("t2 mi cycles", miCnt, 50);
    checkOutput("t2 done count", doneCnt, 1);
    stop = 1; tick(); stop = 0;

    // Test 3: pause 30 cycles in the first gap
    doReset();
    zeroRun = 0; seenDo = 0; paused = 0; pLeft = 0; fin = 0;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 1000 && !fin; k++) begin
      tick();
      if (note_div == RE) fin = 1;
      else if (note_div == DO) seenDo = 1;
      else if (seenDo && note_div == 0) zeroRun++;
      if (pLeft > 0) begin
        pLeft--;
        if (pLeft == 0) begin
          pause = 0;
          checkOutput("t3 idx frozen", int'(note_idx), 0);
        end
      end else if (!paused && zeroRun == 5) begin
        pause = 1; pLeft = 30; paused = 1;
      end
    end
    checkOutput("t3 reached re", int'(fin), 1);
    checkOutput("t3 silent run", zeroRun, 41);
    checkOutput("t3 idx after gap", int'(note_idx), 1);

    // Test 4: start while busy, pause+key, stop+start together, stop in idle
    doReset();
    start = 1; tick(); start = 0;
    repeat (20) tick();
    start = 1; tick(); start = 0;
    checkOutput("t4 start ignored", int'(note_div), int'(DO));
    checkOutput("t4 start ignored idx", int'(note_idx), 0);
    pause = 1; manual_req = 1; manual_div = MI;
    repeat (5) tick();
    checkOutput("t4 pause+manual", int'(note_div), int'(MI));
    pause = 0; manual_req = 0;
    tick();
    checkOutput("t4 resume", int'(note_div), int'(DO));
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    checkOutput("t4 stop note", int'(note_div), 0);
    checkOutput("t4 stop busy", int'(busy), 0);
    checkOutput("t4 stop done", int'(done), 0);
    doneCnt = 0; busyCnt = 0;
    repeat (10) begin
      tick();
      if (done) doneCnt++;
      if (busy) busyCnt++;
    end
    checkOutput("t4 no done", doneCnt, 0);
    checkOutput("t4 stays idle", busyCnt, 0);
    stop = 1; tick(); stop = 0;
    checkOutput("t4 stop in idle", int'(busy), 0);

    // Test 5: reset mid-PLAY with start held
    doReset();
    start = 1; tick(); start = 0;
    repeat (30) tick();
    rst = 1; start = 1; tick();
    checkOutput("t5 rst note", int'(note_div), 0);
    checkOutput("t5 rst busy", int'(busy), 0);
    checkOutput("t5 rst done", int'(done), 0);
    checkOutput("t5 rst idx", int'(note_idx), 0);
    rst = 0; start = 0; tick();
    checkOutput("t5 idle after rst", int'(busy), 0);

    // Test 6: end marker at entry 0
    doReset();
    startE = 1; tick(); startE = 0;
    checkOutput("t6 load busy", int'(busyE), 1);
    checkOutput("t6 load note", int'(noteE), 0);
    tick();
    checkOutput("t6 done pulse", int'(doneE), 1);
    checkOutput("t6 done busy", int'(busyE), 0);
    nzCnt = 0; doneCnt = 0;
    repeat (10) begin
      tick();
      if (noteE != 0) nzCnt++;
      if (doneE) doneCnt++;
    end
    checkOutput("t6 no tone", nzCnt, 0);
    checkOutput("t6 single done", doneCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
